// File: rtl/ahb_burst_pkg.sv
// Shared AHB-Lite encodings, FSM states and burst helpers for the burst tracker.
package ahb_burst_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Zero marks an undefined-length (INCR) burst.
  function automatic logic [4:0] beats_of(hburst_t b);
    case (b)
      HB_SINGLE:          beats_of = 5'd1;
      HB_WRAP4, HB_INCR4:   beats_of = 5'd4;
      HB_WRAP8, HB_INCR8:   beats_of = 5'd8;
      HB_WRAP16, HB_INCR16: beats_of = 5'd16;
      default:            beats_of = 5'd0;
    endcase
  endfunction

  function automatic logic is_wrap(hburst_t b);
    is_wrap = (b == HB_WRAP4) || (b == HB_WRAP8) || (b == HB_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_next_addr.sv
// Combinational next-beat address for incrementing and wrapping AHB bursts.
module ahb_next_addr
  import ahb_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            hsize,
  input  hburst_t               hburst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [31:0]           wrap_bytes;

  // A wrap window wider than the address space degenerates to a full mask.
  always_comb begin
    inc        = ADDR_WIDTH'(32'd1 << hsize);
    wrap_bytes = 32'(beats_of(hburst)) << hsize;
    wrap_mask  = ADDR_WIDTH'(wrap_bytes - 32'd1);
    sum        = addr + inc;
    next_addr  = sum;
    if (is_wrap(hburst))
      next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
  end

endmodule

// File: rtl/ahb_burst_tracker.sv
// AHB-Lite subordinate-side burst tracker: beat count, next address and protocol checks.
// Optional statistics counters are enabled with `AHB_BURST_STATS_EN.
module ahb_burst_tracker
  import ahb_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic                  hwrite,
  input  logic                  hready,
  output logic                  burst_active,
  output logic [4:0]            beat_cnt,
  output logic                  last_beat,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  addr_err,
  output logic                  align_err,
  output logic                  size_err,
  output logic                  attr_err,
  output logic                  early_term
`ifdef AHB_BURST_STATS_EN
  ,
  output logic [15:0]           burst_count,
  output logic [7:0]            err_count
`endif
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  state_t                state, state_nxt;
  hburst_t               burst_q, burst_nxt;
  logic [2:0]            size_q, size_nxt;
  logic                  write_q, write_nxt;
  logic [4:0]            beat_nxt;
  logic [ADDR_WIDTH-1:0] naddr_nxt, size_mask;
  logic                  last_nxt, addr_err_nxt, align_nxt, size_err_nxt, attr_nxt, early_nxt, done_nxt;

  htrans_t               trans;
  hburst_t               hb_in;
  logic                  acc, idle_term, in_burst, start;
  logic [ADDR_WIDTH-1:0] calc_addr, calc_out;
  logic [2:0]            calc_size;
  hburst_t               calc_burst;

  assign trans     = htrans_t'(htrans);
  assign hb_in     = hburst_t'(hburst);
  assign acc       = hsel && hready && (trans != HT_IDLE);
  assign idle_term = hsel && hready && (trans == HT_IDLE);
  assign in_burst  = (state != ST_IDLE);
  assign start     = acc && (trans == HT_NONSEQ);

  // SEQ beats advance from the tracker's own expectation, so one bad address gives one pulse.
  assign calc_addr  = start ? haddr : next_addr;
  assign calc_size  = start ? hsize : size_q;
  assign calc_burst = start ? hb_in : burst_q;

  ahb_next_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_addr (
    .addr      (calc_addr),
    .hsize     (calc_size),
    .hburst    (calc_burst),
    .next_addr (calc_out)
  );

  always_comb begin
    state_nxt    = state;
    burst_nxt    = burst_q;
    size_nxt     = size_q;
    write_nxt    = write_q;
    beat_nxt     = beat_cnt;
    naddr_nxt    = next_addr;
    last_nxt     = 1'b0;
    addr_err_nxt = 1'b0;
    align_nxt    = 1'b0;
    size_err_nxt = 1'b0;
    attr_nxt     = 1'b0;
    early_nxt    = 1'b0;
    done_nxt     = 1'b0;
    size_mask    = ADDR_WIDTH'((32'd1 << hsize) - 32'd1);

    if (acc) begin
      size_err_nxt = (hsize > MAX_SIZE);
      align_nxt    = ((haddr & size_mask) != '0);
    end

    if (start) begin
      if (in_burst && beats_of(burst_q) != 5'd0) early_nxt = 1'b1;
      if (in_burst && burst_q == HB_INCR)        done_nxt  = 1'b1;
      burst_nxt = hb_in;
      size_nxt  = hsize;
      write_nxt = hwrite;
      beat_nxt  = 5'd1;
      naddr_nxt = calc_out;
      if (hb_in == HB_SINGLE) begin
        last_nxt  = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_ACTIVE;
      end
    end else if (acc && trans == HT_SEQ) begin
      if (!in_burst) begin
        addr_err_nxt = 1'b1;
      end else begin
        addr_err_nxt = (haddr != next_addr);
        attr_nxt     = (hb_in != burst_q) || (hsize != size_q) || (hwrite != write_q);
        if (beat_cnt != 5'd31) beat_nxt = beat_cnt + 5'd1;
        naddr_nxt = calc_out;
        if (beats_of(burst_q) != 5'd0 && beat_cnt + 5'd1 == beats_of(burst_q)) begin
          last_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ACTIVE;
        end
      end
    end else if (acc && trans == HT_BUSY) begin
      if (in_burst) state_nxt = ST_HOLD;
    end else if (idle_term && in_burst) begin
      if (beats_of(burst_q) != 5'd0) early_nxt = 1'b1;
      else                           done_nxt  = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      burst_q      <= HB_SINGLE;
      size_q       <= 3'd0;
      write_q      <= 1'b0;
      burst_active <= 1'b0;
      beat_cnt     <= 5'd0;
      next_addr    <= '0;
      last_beat    <= 1'b0;
      addr_err     <= 1'b0;
      align_err    <= 1'b0;
      size_err     <= 1'b0;
      attr_err     <= 1'b0;
      early_term   <= 1'b0;
    end else begin
      state        <= state_nxt;
      burst_q      <= burst_nxt;
      size_q       <= size_nxt;
      write_q      <= write_nxt;
      burst_active <= (state_nxt != ST_IDLE);
      beat_cnt     <= beat_nxt;
      next_addr    <= naddr_nxt;
      last_beat    <= last_nxt;
      addr_err     <= addr_err_nxt;
      align_err    <= align_nxt;
      size_err     <= size_err_nxt;
      attr_err     <= attr_nxt;
      early_term   <= early_nxt;
    end
  end

`ifdef AHB_BURST_STATS_EN
  logic any_err_nxt;
  assign any_err_nxt = addr_err_nxt | align_nxt | size_err_nxt | attr_nxt | early_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_count <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      if (done_nxt && burst_count != 16'hFFFF) burst_count <= burst_count + 16'd1;
      if (any_err_nxt && err_count != 8'hFF)   err_count   <= err_count + 8'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = done_nxt;
`endif

endmodule

// File: tb/tb_ahb_burst_tracker.sv
// Directed self-checking bench for ahb_burst_tracker (ADDR_WIDTH=8, DATA_WIDTH=32).
module tb_ahb_burst_tracker;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_WRAP8 = 3'd4,
                         B_INCR8 = 3'd5, B_WRAP16 = 3'd6;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsel, hwrite, hready;
  logic [7:0] haddr;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  logic       burst_active, last_beat, addr_err, align_err, size_err, attr_err, early_term;
  logic [4:0] beat_cnt;
  logic [7:0] next_addr;
  logic [4:0] errs;
`ifdef AHB_BURST_STATS_EN
  logic [15:0] burst_count;
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  ahb_burst_tracker #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .hsel         (hsel),
    .haddr        (haddr),
    .htrans       (htrans),
    .hsize        (hsize),
    .hburst       (hburst),
    .hwrite       (hwrite),
    .hready       (hready),
    .burst_active (burst_active),
    .beat_cnt     (beat_cnt),
    .last_beat    (last_beat),
    .next_addr    (next_addr),
    .addr_err     (addr_err),
    .align_err    (align_err),
    .size_err     (size_err),
    .attr_err     (attr_err),
    .early_term   (early_term)
`ifdef AHB_BURST_STATS_EN
    ,
    .burst_count  (burst_count),
    .err_count    (err_count)
`endif
  );

  assign errs = {addr_err, align_err, size_err, attr_err, early_term};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [4:0] cnt, input logic [7:0] nxt,
                           input logic last, input logic act, input logic [4:0] err);
    checkOutput({tag, " beat_cnt"}, 32'(beat_cnt), 32'(cnt));
    checkOutput({tag, " next_addr"}, 32'(next_addr), 32'(nxt));
    checkOutput({tag, " last_beat"}, 32'(last_beat), 32'(last));
    checkOutput({tag, " burst_active"}, 32'(burst_active), 32'(act));
    checkOutput({tag, " errs"}, 32'(errs), 32'(err));
  endtask

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [7:0] addr,
                               input logic [2:0] size, input logic [2:0] burst,
                               input logic write, input logic rdy);
    hsel = sel; htrans = trans; haddr = addr; hsize = size;
    hburst = burst; hwrite = write; hready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] w8 [8];
    w8 = '{8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h00, 8'h04, 8'h08};

    rst = 1'b1;
    hsel = 1'b0; htrans = T_IDLE; haddr = 8'h00; hsize = 3'd2;
    hburst = B_SINGLE; hwrite = 1'b0; hready = 1'b1;
    #12;
    checkBeat("reset", 5'd0, 8'h00, 1'b0, 1'b0, 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] WRAP8 word burst from 0x0C");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, w8[i], 3'd2, B_WRAP8, 1'b0, 1'b1);
      checkBeat($sformatf("wrap8 b%0d", i + 1), 5'(i + 1), w8[(i + 1) % 8], (i == 7), (i != 7), 5'b00000);
    end
    applyStimulus(1'b1, T_IDLE, 8'h00, 3'd2, B_SINGLE, 1'b0, 1'b1);
    checkOutput("wrap8 last_beat one cycle", 32'(last_beat), 32'd0);
`ifdef AHB_BURST_STATS_EN
    checkOutput("wrap8 burst_count", 32'(burst_count), 32'd1);
`endif

    $display("[TB] INCR4 address mismatch on beat 3");
    applyStimulus(1'b1, T_NONSEQ, 8'h1C, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("incr4 b1", 5'd1, 8'h20, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_SEQ, 8'h20, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("incr4 b2", 5'd2, 8'h24, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_SEQ, 8'h2C, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("incr4 b3", 5'd3, 8'h28, 1'b0, 1'b1, 5'b10000);
    applyStimulus(1'b1, T_SEQ, 8'h28, 3'd2, B_INCR4, 1'b0, 1'b0);
    checkBeat("incr4 hready low", 5'd3, 8'h28, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_SEQ, 8'h28, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("incr4 b4", 5'd4, 8'h2C, 1'b1, 1'b0, 5'b00000);

    $display("[TB] INCR8 early termination");
    applyStimulus(1'b1, T_NONSEQ, 8'h30, 3'd2, B_INCR8, 1'b0, 1'b1);
    checkBeat("incr8 b1", 5'd1, 8'h34, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_SEQ, 8'h34, 3'd2, B_INCR8, 1'b0, 1'b1);
    applyStimulus(1'b1, T_SEQ, 8'h38, 3'd2, B_INCR8, 1'b0, 1'b1);
    checkBeat("incr8 b3", 5'd3, 8'h3C, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_NONSEQ, 8'h40, 3'd2, B_INCR8, 1'b0, 1'b1);
    checkBeat("incr8 restart", 5'd1, 8'h44, 1'b0, 1'b1, 5'b00001);
    applyStimulus(1'b1, T_IDLE, 8'h00, 3'd2, B_INCR8, 1'b0, 1'b1);
    checkOutput("incr8 idle term early_term", 32'(errs), 32'b00001);
    checkOutput("incr8 idle term burst_active", 32'(burst_active), 32'd0);

    $display("[TB] BUSY inside INCR4");
    applyStimulus(1'b1, T_NONSEQ, 8'h50, 3'd2, B_INCR4, 1'b0, 1'b1);
    applyStimulus(1'b1, T_SEQ, 8'h54, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("busy b2", 5'd2, 8'h58, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_BUSY, 8'h58, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("busy hold1", 5'd2, 8'h58, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_BUSY, 8'h58, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("busy hold2", 5'd2, 8'h58, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_SEQ, 8'h58, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("busy b3", 5'd3, 8'h5C, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_SEQ, 8'h5C, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("busy b4", 5'd4, 8'h60, 1'b1, 1'b0, 5'b00000);

    $display("[TB] size, alignment and attribute errors");
    applyStimulus(1'b1, T_NONSEQ, 8'h00, 3'd3, B_SINGLE, 1'b0, 1'b1);
    checkBeat("single dword", 5'd1, 8'h08, 1'b1, 1'b0, 5'b00100);
    applyStimulus(1'b1, T_NONSEQ, 8'h02, 3'd2, B_SINGLE, 1'b0, 1'b1);
    checkBeat("single misaligned", 5'd1, 8'h06, 1'b1, 1'b0, 5'b01000);
    applyStimulus(1'b1, T_NONSEQ, 8'h60, 3'd2, B_INCR, 1'b0, 1'b1);
    checkBeat("incr b1", 5'd1, 8'h64, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b1, T_SEQ, 8'h64, 3'd2, B_INCR, 1'b1, 1'b1);
    checkBeat("incr hwrite flip", 5'd2, 8'h68, 1'b0, 1'b1, 5'b00010);
    applyStimulus(1'b1, T_IDLE, 8'h00, 3'd2, B_INCR, 1'b0, 1'b1);
    checkOutput("incr end errs", 32'(errs), 32'b00000);
    checkOutput("incr end burst_active", 32'(burst_active), 32'd0);
`ifdef AHB_BURST_STATS_EN
    checkOutput("burst_count total", 32'(burst_count), 32'd6);
    checkOutput("err_count total", 32'(err_count), 32'd6);
`endif

    $display("[TB] reset during WRAP16");
    applyStimulus(1'b1, T_NONSEQ, 8'h80, 3'd2, B_WRAP16, 1'b0, 1'b1);
    applyStimulus(1'b1, T_SEQ, 8'h84, 3'd2, B_WRAP16, 1'b0, 1'b1);
    applyStimulus(1'b1, T_SEQ, 8'h88, 3'd2, B_WRAP16, 1'b0, 1'b1);
    applyStimulus(1'b1, T_SEQ, 8'h8C, 3'd2, B_WRAP16, 1'b0, 1'b1);
    checkBeat("wrap16 b4", 5'd4, 8'h90, 1'b0, 1'b1, 5'b00000);
    htrans = T_SEQ; haddr = 8'h90;
    #2 rst = 1'b1;
    #1;
    checkBeat("async reset", 5'd0, 8'h00, 1'b0, 1'b0, 5'b00000);
`ifdef AHB_BURST_STATS_EN
    checkOutput("reset burst_count", 32'(burst_count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, T_NONSEQ, 8'hA0, 3'd2, B_INCR4, 1'b0, 1'b1);
    checkBeat("post reset b1", 5'd1, 8'hA4, 1'b0, 1'b1, 5'b00000);
    applyStimulus(1'b0, T_IDLE, 8'h00, 3'd2, B_SINGLE, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
